// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard frame receiver and scan-code to button-code encoder.
// Emits key_dec one cycle ahead of a single-cycle latch strobe.
module ps2_key_encoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_dec,
    output logic       latch,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pstate_t;

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall;
    logic          bit_in;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          byte_rdy;
    logic          stop_err;
    pstate_t       state, nxt;
    logic          ev_valid;
    logic          ev_brk;
    logic [7:0]    ev_code;
    logic [7:0]    held;
    logic          latch_pend;

    function automatic logic [7:0] map_plain(input logic [7:0] sc);
        case (sc)
            8'h32:   return 8'h01;
            8'h35:   return 8'h02;
            8'h1C:   return 8'h09;
            8'h22:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] map_ext(input logic [7:0] sc);
        case (sc)
            8'h75:   return 8'h05;
            8'h72:   return 8'h06;
            8'h6B:   return 8'h07;
            8'h74:   return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    // Sync stages reset high so a released bus never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // shreg holds the received byte while byte_rdy is high; the next shift is a full bit away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            byte_rdy  <= 1'b0;
            stop_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            stop_err  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (bit_cnt)
                    4'd0: if (!bit_in) bit_cnt <= 4'd1;
                    4'd9: begin
                        par_bit <= bit_in;
                        bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt <= 4'd0;
                        if (bit_in && (^{shreg, par_bit})) begin
                            byte_rdy <= 1'b1;
                        end else begin
                            stop_err  <= 1'b1;
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                endcase
            end else begin
                if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
                if (tcnt == TMAX && bit_cnt != 4'd0) begin
                    bit_cnt   <= 4'd0;
                    frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (stop_err) begin
            nxt = S_IDLE;
        end else if (byte_rdy) begin
            case (state)
                S_IDLE: begin
                    if (shreg == SC_EXT)      nxt = S_EXT;
                    else if (shreg == SC_BRK) nxt = S_BRK;
                    else                      nxt = S_IDLE;
                end
                S_EXT:   nxt = (shreg == SC_BRK) ? S_EXT_BRK : S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_brk   = 1'b0;
        ev_code  = 8'h00;
        if (byte_rdy) begin
            case (state)
                S_IDLE: begin
                    ev_valid = (shreg != SC_EXT) && (shreg != SC_BRK);
                    ev_code  = map_plain(shreg);
                end
                S_EXT: begin
                    ev_valid = (shreg != SC_BRK);
                    ev_code  = map_ext(shreg);
                end
                S_BRK: begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                    ev_code  = map_plain(shreg);
                end
                default: begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                    ev_code  = map_ext(shreg);
                end
            endcase
        end
    end

    // A zero ev_code means unmapped; repeats of the held make are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held       <= 8'h00;
            key_dec    <= 8'h00;
            latch_pend <= 1'b0;
            latch      <= 1'b0;
        end else begin
            latch_pend <= 1'b0;
            latch      <= latch_pend;
            if (ev_valid && ev_code != 8'h00) begin
                if (!ev_brk && ev_code != held) begin
                    held       <= ev_code;
                    key_dec    <= ev_code;
                    latch_pend <= 1'b1;
                end else if (ev_brk && ev_code == held) begin
                    held       <= 8'h00;
                    key_dec    <= 8'h00;
                    latch_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: drives raw PS/2 frames and checks emitted button
// events against a key-event level model of press/release behaviour.
module tb_ps2_key_encoder;

    localparam int TO   = 200;
    localparam int HALF = 5;
    localparam int GAP  = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_dec;
    logic       latch;
    logic       frame_err;

    ps2_key_encoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_dec   (key_dec),
        .latch     (latch),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records latch pulses and frame errors, flags timing violations.
    logic [7:0] lat_q[$];
    int         latch_cnt = 0;
    int         err_cnt = 0;
    int         timing_viol = 0;
    int         err_wide = 0;
    int         latch_cyc = 0;
    logic       prev_latch = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] prev_key = 8'h00;
    logic [7:0] prev2_key = 8'h00;

    always @(negedge clk) begin
        if (latch && !prev_latch) begin
            latch_cnt <= latch_cnt + 1;
            lat_q.push_back(key_dec);
            latch_cyc <= cyc;
            if (!(key_dec == prev_key && prev_key != prev2_key)) timing_viol <= timing_viol + 1;
        end
        if (latch && prev_latch) timing_viol <= timing_viol + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_err && prev_ferr) err_wide <= err_wide + 1;
        prev2_key  <= prev_key;
        prev_key   <= key_dec;
        prev_latch <= latch;
        prev_ferr  <= frame_err;
    end

    int n_assert = 0;
    int n_fail = 0;
    int last_fall_cyc = 0;
    int stop_cyc = 0;
    logic [7:0] held_m = 8'h00;

    logic [7:0] sc_tab [12] = '{8'h32, 8'h35, 8'h1C, 8'h22, 8'h75, 8'h72,
                                8'h6B, 8'h74, 8'h75, 8'h1C, 8'h15, 8'h29};
    bit         ext_tab[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_map(input bit ext, input logic [7:0] sc);
        if (!ext) begin
            case (sc)
                8'h32:   return 8'h01;
                8'h35:   return 8'h02;
                8'h1C:   return 8'h09;
                8'h22:   return 8'h0A;
                default: return 8'h00;
            endcase
        end
        case (sc)
            8'h75:   return 8'h05;
            8'h72:   return 8'h06;
            8'h6B:   return 8'h07;
            8'h74:   return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        stop_cyc = last_fall_cyc;
        repeat (GAP) @(negedge clk);
    endtask

    // Sends one key event as PS/2 bytes and checks the outcome against the model.
    task automatic key_event(input bit ext, input bit brk, input logic [7:0] sc);
        int         l0, e0;
        logic [7:0] code, val;
        bit         emit;
        l0 = latch_cnt;
        e0 = err_cnt;
        if (ext) send_frame(8'hE0, 1'b0, 11);
        if (brk) send_frame(8'hF0, 1'b0, 11);
        send_frame(sc, 1'b0, 11);
        code = ref_map(ext, sc);
        emit = 1'b0;
        val  = 8'h00;
        if (code != 8'h00) begin
            if (!brk && code != held_m) begin
                emit = 1'b1; val = code; held_m = code;
            end else if (brk && code == held_m) begin
                emit = 1'b1; val = 8'h00; held_m = 8'h00;
            end
        end
        check("latch_count", latch_cnt - l0, {31'd0, emit});
        check("frame_err_count", err_cnt - e0, 0);
        if (emit && lat_q.size() > 0) check("latched_value", lat_q.pop_front(), val);
        check("key_dec_held", key_dec, val | (emit ? 8'h00 : held_m));
    endtask

    initial begin
        int l0, e0, lat, idx;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_key_dec", key_dec, 8'h00);
        check("reset_latch", latch, 0);
        check("reset_frame_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        key_event(1'b0, 1'b0, 8'h1C);
        lat = latch_cyc - stop_cyc;
        check("latency_in_range", (lat >= 1 && lat <= 6), 1);

        key_event(1'b0, 1'b0, 8'h1C);
        key_event(1'b0, 1'b1, 8'h1C);

        key_event(1'b1, 1'b0, 8'h75);
        key_event(1'b1, 1'b1, 8'h75);
        key_event(1'b0, 1'b0, 8'h75);
        key_event(1'b1, 1'b0, 8'h1C);

        l0 = latch_cnt; e0 = err_cnt;
        send_frame(8'h32, 1'b1, 11);
        check("bad_parity_err", err_cnt - e0, 1);
        check("bad_parity_latch", latch_cnt - l0, 0);
        check("bad_parity_key_dec", key_dec, held_m);
        key_event(1'b0, 1'b0, 8'h32);

        l0 = latch_cnt; e0 = err_cnt;
        send_frame(8'h35, 1'b0, 5);
        repeat (TO + 10) @(negedge clk);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_latch", latch_cnt - l0, 0);
        key_event(1'b0, 1'b0, 8'h35);

        e0 = err_cnt;
        ps2_bit(1'b1);
        repeat (GAP) @(negedge clk);
        check("start_one_no_err", err_cnt - e0, 0);

        key_event(1'b0, 1'b0, 8'h1C);
        key_event(1'b0, 1'b0, 8'h22);
        key_event(1'b0, 1'b1, 8'h1C);
        key_event(1'b0, 1'b1, 8'h22);

        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 11);
            key_event(ext_tab[idx], $urandom_range(0, 1) == 1, sc_tab[idx]);
        end

        key_event(1'b0, 1'b0, 8'h1C);
        send_frame(8'h22, 1'b0, 5);
        reset_n = 1'b0;
        #1;
        check("midframe_reset_key_dec", key_dec, 8'h00);
        check("midframe_reset_latch", latch, 0);
        check("midframe_reset_frame_err", frame_err, 0);
        held_m = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (TO + 10) @(negedge clk);
        key_event(1'b0, 1'b0, 8'h1C);

        check("latch_timing_violations", timing_viol, 0);
        check("frame_err_width", err_wide, 0);
        check("unconsumed_latches", lat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
